// File: rtl/bcd_sub_seq.sv
// bcd_sub_seq: digit-serial BCD |A-B| with sign flag, one shared subtract/borrow stage
module bcd_sub_seq #(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] Y,
  output logic                neg,
  output logic                err
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int W = 4 * DIGITS;
  typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;
  state_t r_state, w_state;
  logic [IW-1:0] r_idx, w_idx;
  logic r_borrow, w_borrow, r_neg, w_neg, r_err, w_err;
  logic [W-1:0] r_a, w_a, r_b, w_b, r_work, w_work, r_y, w_y;
  logic [3:0] w_x, w_s, w_digit;
  logic [4:0] w_d;
  logic w_bout, w_last, w_valid;
  // shared digit stage: NEG pass subtracts the work digit from zero (ten's complement)
  always_comb begin
    w_x = r_state == NEG ? 4'd0 : r_a[4*r_idx +: 4];
    w_s = r_state == NEG ? r_work[4*r_idx +: 4] : r_b[4*r_idx +: 4];
    w_d = {1'b0, w_x} - {1'b0, w_s} - {4'd0, r_borrow};
    w_bout = w_d[4];
    w_digit = w_bout ? w_d[3:0] + 4'd10 : w_d[3:0];
    w_last = r_idx == IW'(DIGITS - 1);
  end
  // operands are accepted only when every digit of both is a legal BCD digit
  always_comb begin
    w_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9) w_valid = 1'b0;
  end
  // next-state and datapath updates
  always_comb begin
    w_state = r_state;
    w_idx = r_idx;
    w_borrow = r_borrow;
    w_a = r_a;
    w_b = r_b;
    w_work = r_work;
    w_y = r_y;
    w_neg = r_neg;
    w_err = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        if (w_valid) begin
          w_a = A;
          w_b = B;
          w_idx = '0;
          w_borrow = 1'b0;
          w_state = SUB;
        end else w_err = 1'b1;
      end
      SUB, NEG: begin
        w_work[4*r_idx +: 4] = w_digit;
        w_borrow = w_bout;
        w_idx = r_idx + 1'b1;
        if (w_last) begin
          w_idx = '0;
          if (r_state == SUB && w_bout) begin
            w_borrow = 1'b0;
            w_state = NEG;
          end else begin
            w_borrow = 1'b0;
            w_y = w_work;
            w_neg = r_state == NEG;
            w_state = DONE;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_borrow <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_work <= '0;
      r_y <= '0;
      r_neg <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx <= w_idx;
      r_borrow <= w_borrow;
      r_a <= w_a;
      r_b <= w_b;
      r_work <= w_work;
      r_y <= w_y;
      r_neg <= w_neg;
      r_err <= w_err;
    end
  end
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign Y = r_y;
  assign neg = r_neg;
  assign err = r_err;
endmodule

// File: tb/tb_bcd_sub_seq.sv
// tb_bcd_sub_seq: directed self-checking bench for the digit-serial BCD subtractor
module tb_bcd_sub_seq;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [11:0] a = '0, b = '0;
  logic busy, done, neg, err;
  logic [11:0] y;
  int checks = 0, errors = 0;
  bcd_sub_seq #(.DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
    .busy(busy), .done(done), .Y(y), .neg(neg), .err(err)
  );
  always #5 clk = ~clk;
  // drive a one-cycle start; returns at the negedge after the accept edge (edge 0)
  task automatic pulse_start(input logic [11:0] av, input logic [11:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  // count edges after edge 0 until done is seen, bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (y !== 12'h000) begin errors++; $display("FAIL reset_y got %h want 000", y); end
    checks++; if (neg !== 1'b0) begin errors++; $display("FAIL reset_neg got %b want 0", neg); end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_positive;
    int lat;
    pulse_start(12'h523, 12'h187);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pos_busy got %b want 1", busy); end
    wait_done(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL pos_latency got %0d want 3", lat); end
    checks++; if (y !== 12'h336) begin errors++; $display("FAIL pos_y got %h want 336", y); end
    checks++; if (neg !== 1'b0) begin errors++; $display("FAIL pos_neg got %b want 0", neg); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL pos_after got done=%b busy=%b want 0 0", done, busy); end
  endtask
  task automatic test_negative;
    int lat;
    pulse_start(12'h187, 12'h523);
    wait_done(lat);
    checks++; if (lat != 6) begin errors++; $display("FAIL neg_latency got %0d want 6", lat); end
    checks++; if (y !== 12'h336) begin errors++; $display("FAIL neg_y got %h want 336", y); end
    checks++; if (neg !== 1'b1) begin errors++; $display("FAIL neg_neg got %b want 1", neg); end
    @(negedge clk);
  endtask
  task automatic test_borrow_chains;
    logic [11:0] va [3] = '{12'h100, 12'h456, 12'h000};
    logic [11:0] vb [3] = '{12'h001, 12'h456, 12'h999};
    logic [11:0] vy [3] = '{12'h099, 12'h000, 12'h999};
    logic vn [3] = '{1'b0, 1'b0, 1'b1};
    int vl [3] = '{3, 3, 6};
    int lat;
    for (int i = 0; i < 3; i++) begin
      pulse_start(va[i], vb[i]);
      wait_done(lat);
      checks++; if (lat != vl[i]) begin errors++; $display("FAIL chain%0d_latency got %0d want %0d", i, lat, vl[i]); end
      checks++; if (y !== vy[i]) begin errors++; $display("FAIL chain%0d_y got %h want %h", i, y, vy[i]); end
      checks++; if (neg !== vn[i]) begin errors++; $display("FAIL chain%0d_neg got %b want %b", i, neg, vn[i]); end
      @(negedge clk);
    end
  endtask
  task automatic test_invalid;
    pulse_start(12'h1A3, 12'h001);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL inv_err got %b want 1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inv_busy got %b want 0", busy); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL inv_err_pulse got %b want 0", err); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL inv_idle got done=%b busy=%b want 0 0", done, busy); end
    checks++; if (y !== 12'h999 || neg !== 1'b1) begin errors++; $display("FAIL inv_hold got y=%h neg=%b want 999 1", y, neg); end
  endtask
  task automatic test_back_to_back;
    int lat;
    pulse_start(12'h523, 12'h187);
    a = 12'h999;
    b = 12'h000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL ign_latency got %0d want 2", lat); end
    checks++; if (y !== 12'h336 || neg !== 1'b0) begin errors++; $display("FAIL ign_result got y=%h neg=%b want 336 0", y, neg); end
    @(negedge clk);
    pulse_start(12'h999, 12'h111);
    wait_done(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL b2b_latency got %0d want 3", lat); end
    checks++; if (y !== 12'h888 || neg !== 1'b0) begin errors++; $display("FAIL b2b_result got y=%h neg=%b want 888 0", y, neg); end
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    int lat;
    pulse_start(12'h187, 12'h523);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_ctrl got busy=%b done=%b want 0 0", busy, done); end
    checks++; if (y !== 12'h000 || neg !== 1'b0) begin errors++; $display("FAIL rmid_out got y=%h neg=%b want 000 0", y, neg); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_idle got busy=%b done=%b want 0 0", busy, done); end
    pulse_start(12'h050, 12'h049);
    wait_done(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL rmid_latency got %0d want 3", lat); end
    checks++; if (y !== 12'h001 || neg !== 1'b0) begin errors++; $display("FAIL rmid_result got y=%h neg=%b want 001 0", y, neg); end
  endtask
  initial begin
    test_reset;
    test_positive;
    test_negative;
    test_borrow_chains;
    test_invalid;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_sub_seq.md
Name: bcd_sub_seq

Overview:
Digit-serial BCD subtractor sequencer. It computes |A − B| and a sign flag for DIGITS-digit packed-BCD operands using one shared single-digit subtract/borrow stage, stepped one digit per clock from least significant to most significant. A negative result gets a second ten's-complement pass through the same stage to produce the magnitude. It sits between operand registers (keypad/switch capture) and the 7-segment display driver, and replaces the parallel per-digit subtractor chain when area matters.

Parameters:
DIGITS, 3, number of BCD digits per operand (legal range 1..8)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only when busy=0
A  in  4*DIGITS  minuend, packed BCD, digit 0 = bits [3:0]
B  in  4*DIGITS  subtrahend, packed BCD
busy  out  1  high while an operation is in progress
done  out  1  single-cycle completion pulse
Y  out  4*DIGITS  registered result magnitude, packed BCD
neg  out  1  registered sign; 1 = A < B
err  out  1  single-cycle pulse; start rejected because an input digit > 9

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, err=0, Y=0, neg=0, internal digit index=0, borrow=0, operand and work registers=0. Deasserting rst mid-operation leaves the block in IDLE. The operation in progress is lost and no done is issued.
- FSM states: IDLE, SUB, NEG, DONE. busy=1 in SUB, NEG and DONE.
- IDLE: if start=1 and every digit of A and B is ≤ 9, latch A and B, set idx=0, borrow=0, and go to SUB. This edge is edge 0. If start=1 and any digit is > 9, raise err for exactly one cycle and stay in IDLE; Y, neg and done are unchanged.
- Digit stage, used by both SUB and NEG: d = x − y − borrow, computed as a 5-bit signed value. If d < 0, digit = d + 10 and borrow_next = 1. Otherwise digit = d and borrow_next = 0. Output is always 0..9.
- SUB: x = A[idx], y = B[idx]. Write the stage digit into work[idx], update borrow, idx++. On the edge that processes idx = DIGITS−1 (edge DIGITS):
  - borrow_next = 0: copy work to Y, set neg=0, go to DONE.
  - borrow_next = 1: set idx=0, borrow=0, go to NEG.
- NEG: x = 0, y = work[idx]. Write the stage digit into work[idx], idx++. On the last digit (edge 2*DIGITS), copy work to Y, set neg=1, go to DONE. The final borrow of this pass is discarded.
- DONE: done=1 for exactly this one cycle. The next edge returns to IDLE unconditionally. start is ignored while in DONE.
- Latency: done, Y and neg update on edge DIGITS when A ≥ B, and on edge 2*DIGITS when A < B. Edges are counted from the start-accept edge.
- Y and neg hold their values from one done until the next done. They never show partial results.
- start while busy=1: ignored, not queued. The latched operands are not disturbed by changes on A and B after edge 0.
- A = B gives Y = 0, neg = 0. A result of −0 never occurs.
- DIGITS = 1: the single SUB edge is also the last digit. The same rules apply.

Test Plan:
- DIGITS=3, A=0x523, B=0x187, start pulse → busy for 3 edges, done at edge 3, Y=0x336, neg=0.
- A=0x187, B=0x523 → SUB produces work=0x664 with borrow, NEG pass follows, done at edge 6, Y=0x336, neg=1.
- Borrow chains: A=0x100, B=0x001 → Y=0x099, neg=0. A=0x000, B=0x999 → Y=0x999, neg=1. A=B=0x456 → Y=0x000, neg=0.
- Invalid input: A=0x1A3, B=0x001, start → err high one cycle at edge 0, busy stays 0, no done, Y keeps its previous value.
- Change A and B and pulse start during SUB of a 0x523−0x187 operation → start ignored, result still 0x336. A second start issued after done is accepted normally.
- Assert rst at edge 2 of a negative operation → all outputs zero immediately, busy=0, no done. After release, a new 0x050−0x049 operation gives Y=0x001, neg=0 at edge 3.
